// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg
// Shared definitions for the reset sequencer slice:
//   SeqState  - sequencer FSM state encoding (HOLD, STAGE, RUN)
//   RUN_CNT_W - width of the run-cycle counter exposed on run_cycles
//   satInc    - saturating increment used by the run-cycle counter
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        STAGE = 2'd1,
        RUN   = 2'd2
    } SeqState;

    localparam int RUN_CNT_W = 32;

    // Counting stops at all-ones so a long-running system never wraps back to
    // a small run count.
    function automatic logic [RUN_CNT_W-1:0] satInc(input logic [RUN_CNT_W-1:0] value);
        return (value == '1) ? value : value + RUN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// BtnDebounce (module btn_debounce)
// Brings an asynchronous push-button into the clk domain and qualifies it.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset, clears synchronizer and counter
//   i_btn       - raw asynchronous active-high button
//   o_accepted  - high while the synchronized button has been high for at
//                 least DEBOUNCE consecutive cycles
module btn_debounce
    import rst_seq_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_accepted
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_highCnt;
    logic       r_accepted;

    // Two-flop synchronizer followed by a run-length counter of high samples.
    // The counter parks at DEBOUNCE-1 once the button is accepted, and any low
    // synchronized sample drops both the count and the acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_highCnt  <= '0;
            r_accepted <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_highCnt  <= '0;
                r_accepted <= 1'b0;
            end else if (r_highCnt == CNT_LAST) begin
                r_accepted <= 1'b1;
            end else begin
                r_highCnt  <= r_highCnt + 8'd1;
                r_accepted <= 1'b0;
            end
        end
    end

    assign o_accepted = r_accepted;

endmodule

// File: rtl/reset_sequencer.sv
// ResetSequencer (module reset_sequencer)
// Holds a set of reset domains in reset after power-on or a debounced button
// press, then releases them one at a time in ascending order.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low master reset
//   btn_rst     - asynchronous active-high button reset
//   rst_out     - active-high per-domain resets, bit 0 released first
//   all_ready   - registered, high while every rst_out bit is low
//   run_cycles  - cycles since all_ready rose, saturating
//   timeout     - sticky flag once run_cycles reaches TIMEOUT_CYCLES (0 = off)
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int          CHANNELS       = 3,
    parameter int          HOLD_CYCLES    = 25,
    parameter int          STAGE_GAP      = 4,
    parameter int          DEBOUNCE       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_rst,
    output logic [CHANNELS-1:0]  rst_out,
    output logic                 all_ready,
    output logic [RUN_CNT_W-1:0] run_cycles,
    output logic                 timeout
);

    localparam logic [15:0]          HOLD_LAST   = 16'(HOLD_CYCLES - 1);
    localparam logic [7:0]           GAP_LAST    = 8'(STAGE_GAP - 1);
    localparam logic [RUN_CNT_W-1:0] TIMEOUT_VAL = RUN_CNT_W'(TIMEOUT_CYCLES);

    SeqState              r_state;
    logic [15:0]          r_holdCnt;
    logic [7:0]           r_gapCnt;
    logic [CHANNELS-1:0]  r_rstOut;
    logic                 r_allReady;
    logic [RUN_CNT_W-1:0] r_runCycles;
    logic                 r_timeout;

    logic                 w_btnAccepted;
    logic [CHANNELS-1:0]  w_rstShift;
    logic [RUN_CNT_W-1:0] w_runNext;
    logic                 w_timeoutHit;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_btnDebounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_btn      (btn_rst),
        .o_accepted (w_btnAccepted)
    );

    // Releases always go lowest-still-held bit first, so shifting the reset
    // vector left with zero fill releases exactly the next domain.
    assign w_rstShift = r_rstOut << 1;
    assign w_runNext  = satInc(r_runCycles);

    // The flag fires on the edge that makes run_cycles equal the limit; a
    // button reset on that same edge clears run_cycles instead, so it must
    // not set the flag.
    assign w_timeoutHit = (TIMEOUT_CYCLES != 0) && r_allReady && !w_btnAccepted &&
                          (w_runNext == TIMEOUT_VAL);

    // Sequencer FSM. A debounced button press overrides every state and
    // restarts the hold; the hold counter only runs once the press is gone.
    // all_ready follows rst_out by one cycle, and run_cycles starts at 0 on
    // the cycle all_ready rises. The timeout flag survives button resets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HOLD;
            r_holdCnt   <= '0;
            r_gapCnt    <= '0;
            r_rstOut    <= '1;
            r_allReady  <= 1'b0;
            r_runCycles <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_timeoutHit) begin
                r_timeout <= 1'b1;
            end
            if (w_btnAccepted) begin
                r_state     <= HOLD;
                r_holdCnt   <= '0;
                r_gapCnt    <= '0;
                r_rstOut    <= '1;
                r_allReady  <= 1'b0;
                r_runCycles <= '0;
            end else begin
                r_allReady  <= (r_rstOut == '0);
                r_runCycles <= r_allReady ? w_runNext : '0;
                case (r_state)
                    HOLD: begin
                        if (r_holdCnt == HOLD_LAST) begin
                            r_state   <= STAGE;
                            r_holdCnt <= '0;
                            r_gapCnt  <= '0;
                            r_rstOut  <= w_rstShift;
                        end else begin
                            r_holdCnt <= r_holdCnt + 16'd1;
                        end
                    end
                    STAGE: begin
                        if (r_rstOut == '0) begin
                            r_state <= RUN;
                        end else if (r_gapCnt == GAP_LAST) begin
                            r_gapCnt <= '0;
                            r_rstOut <= w_rstShift;
                            if (w_rstShift == '0) begin
                                r_state <= RUN;
                            end
                        end else begin
                            r_gapCnt <= r_gapCnt + 8'd1;
                        end
                    end
                    RUN: begin
                        r_state <= RUN;
                    end
                    default: begin
                        r_state <= HOLD;
                    end
                endcase
            end
        end
    end

    assign rst_out    = r_rstOut;
    assign all_ready  = r_allReady;
    assign run_cycles = r_runCycles;
    assign timeout    = r_timeout;

endmodule
